// File: rtl/bram32_arb_pkg.sv
// bram32_arb_pkg: shared types, sub-address codes and access-decode helpers
// for the bram32 two-port arbiter.
package bram32_arb_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [2:0] SUB_WORD  = 3'd1;
    localparam logic [2:0] SUB_HALF0 = 3'd2;
    localparam logic [2:0] SUB_BYTE0 = 3'd4;

    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lsb);
        return (size == 2'd3) || (size == SIZE_HALF && lsb[0]) || (size == SIZE_WORD && lsb != 2'b00);
    endfunction

    // Size 3 falls through to the byte encoding; the write is suppressed anyway.
    function automatic logic [2:0] sub_addr(input logic [1:0] size, input logic [1:0] lsb);
        return size == SIZE_WORD ? SUB_WORD :
               size == SIZE_HALF ? SUB_HALF0 + {2'b00, lsb[1]} :
                                   SUB_BYTE0 + {1'b0, lsb};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter; on a tie the port that did not
// win last time is granted.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last;

    always_comb begin
        o_gnt0 = i_en && i_req0 && (!i_req1 || r_last);
        o_gnt1 = i_en && i_req1 && (!i_req0 || !r_last);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last <= 1'b1;
        else if (o_gnt0 || o_gnt1)
            r_last <= o_gnt1;
    end

endmodule

// File: rtl/bram32_arbiter.sv
// bram32_arbiter: shares one bram32 between an instruction-fetch port and a
// load/store port, with optional zero-fill of the memory after reset.
module bram32_arbiter
    import bram32_arb_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter bit CLEAR_ON_RESET = 1'b0,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_p0_req,
    input  logic [ADDR_WIDTH+1:0] i_p0_addr,
    input  logic                  i_p0_we,
    input  logic [1:0]            i_p0_size,
    input  logic [31:0]           i_p0_wdata,
    output logic                  o_p0_gnt,
    output logic                  o_p0_rvalid,
    output logic [31:0]           o_p0_rdata,
    output logic                  o_p0_err,
    input  logic                  i_p1_req,
    input  logic [ADDR_WIDTH+1:0] i_p1_addr,
    input  logic                  i_p1_we,
    input  logic [1:0]            i_p1_size,
    input  logic [31:0]           i_p1_wdata,
    output logic                  o_p1_gnt,
    output logic                  o_p1_rvalid,
    output logic [31:0]           o_p1_rdata,
    output logic                  o_p1_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic                  o_mem_we,
    output logic [2:0]            o_mem_wr_subaddr,
    input  logic [31:0]           i_mem_data,
    output logic                  o_busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   r_clr_addr;
    logic                  r_rsp_valid, r_rsp_port, r_rsp_err;
    logic                  busy, gnt0, gnt1, accept, sel, bad, we, clr_done;
    logic [ADDR_WIDTH+1:0] addr;
    logic [1:0]            size;
    logic [31:0]           wdata;

    rr_arb2 u_arb (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (!busy),
        .i_req0 (i_p0_req),
        .i_req1 (i_p1_req),
        .o_gnt0 (gnt0),
        .o_gnt1 (gnt1)
    );

    always_comb begin
        busy     = state_q == ST_CLEAR;
        accept   = gnt0 || gnt1;
        sel      = gnt1;
        addr     = sel ? i_p1_addr : i_p0_addr;
        size     = sel ? i_p1_size : i_p0_size;
        we       = sel ? i_p1_we : i_p0_we;
        wdata    = sel ? i_p1_wdata : i_p0_wdata;
        bad      = access_bad(size, addr[1:0]);
        clr_done = r_clr_addr == (ADDR_WIDTH+1)'(DEPTH - 1);
        state_d  = busy && clr_done ? ST_RUN : state_q;
        // Clear owns the memory port outright; otherwise the winner drives it.
        o_mem_addr       = busy ? r_clr_addr[ADDR_WIDTH-1:0] : accept ? addr[ADDR_WIDTH+1:2] : '0;
        o_mem_data       = accept ? wdata : '0;
        o_mem_we         = busy || (accept && we && !bad);
        o_mem_wr_subaddr = accept ? sub_addr(size, addr[1:0]) : SUB_WORD;
        o_busy           = busy;
        o_p0_gnt         = gnt0;
        o_p1_gnt         = gnt1;
        o_p0_rvalid      = r_rsp_valid && !r_rsp_port;
        o_p1_rvalid      = r_rsp_valid && r_rsp_port;
        o_p0_err         = o_p0_rvalid && r_rsp_err;
        o_p1_err         = o_p1_rvalid && r_rsp_err;
        o_p0_rdata       = i_mem_data;
        o_p1_rdata       = i_mem_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_rsp_valid <= accept;
            if (busy)
                r_clr_addr <= r_clr_addr + (ADDR_WIDTH+1)'(1);
            if (accept) begin
                r_rsp_port <= sel;
                r_rsp_err  <= bad;
            end
        end
    end

endmodule

// File: tb/tb_bram32_arbiter.sv
// tb_bram32_arbiter: randomized and directed checks of bram32_arbiter against
// a byte-level memory model, with a simple bram32 stand-in attached.
module tb_bram32_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic [10:0] addr [2];
    logic        we [2];
    logic [1:0]  size [2];
    logic [31:0] wdata [2];
    logic        gnt0, gnt1, rv0, rv1, err0, err1, busy, mem_we;
    logic [31:0] rd0, rd1, mem_data, mem_q;
    logic [8:0]  mem_addr;
    logic [2:0]  mem_sub;

    logic [31:0] bmem [512] = '{default: 32'hFFFF_FFFF};
    logic [31:0] ref_mem [512];
    logic        last;
    logic [31:0] lrd;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    bram32_arbiter #(.DEPTH(512), .CLEAR_ON_RESET(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(req[0]), .i_p0_addr(addr[0]), .i_p0_we(we[0]), .i_p0_size(size[0]), .i_p0_wdata(wdata[0]),
        .o_p0_gnt(gnt0), .o_p0_rvalid(rv0), .o_p0_rdata(rd0), .o_p0_err(err0),
        .i_p1_req(req[1]), .i_p1_addr(addr[1]), .i_p1_we(we[1]), .i_p1_size(size[1]), .i_p1_wdata(wdata[1]),
        .o_p1_gnt(gnt1), .o_p1_rvalid(rv1), .o_p1_rdata(rd1), .o_p1_err(err1),
        .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_we(mem_we), .o_mem_wr_subaddr(mem_sub),
        .i_mem_data(mem_q), .o_busy(busy)
    );

    // bram32 stand-in: synchronous read of the post-write word.
    always @(posedge clk) begin
        logic [31:0] w;
        w = bmem[mem_addr];
        if (mem_we) begin
            if (mem_sub == 3'd1) w = mem_data;
            else if (mem_sub[2]) w[8*mem_sub[1:0] +: 8] = mem_data[7:0];
            else w[16*mem_sub[0] +: 16] = mem_data[15:0];
            bmem[mem_addr] = w;
        end
        mem_q <= w;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // An access is legal only if naturally aligned to its byte count.
    function automatic logic illegal(input logic [1:0] sz, input logic [10:0] a);
        return sz == 2'd3 || (int'(a) % (1 << sz)) != 0;
    endfunction

    task automatic ref_write(input logic [1:0] sz, input logic [10:0] a, input logic [31:0] d);
        for (int b = 0; b < (1 << sz); b++)
            ref_mem[a[10:2]][8*(int'(a[1:0]) + b) +: 8] = d[8*b +: 8];
    endtask

    task automatic cycle();
        logic g0, g1, p, bad, acc;
        logic [31:0] e;
        #1;
        g0 = req[0] && (!req[1] || last);
        g1 = req[1] && (!req[0] || !last);
        chk("gnt0", {31'b0, gnt0}, {31'b0, g0});
        chk("gnt1", {31'b0, gnt1}, {31'b0, g1});
        acc = g0 || g1;
        p = g1;
        bad = 1'b0;
        e = '0;
        if (acc) begin
            bad = illegal(size[p], addr[p]);
            chk("mem_addr", {23'b0, mem_addr}, {23'b0, addr[p][10:2]});
            chk("mem_we", {31'b0, mem_we}, {31'b0, we[p] && !bad});
            if (we[p] && !bad) ref_write(size[p], addr[p], wdata[p]);
            e = ref_mem[addr[p][10:2]];
            last = p;
        end else begin
            chk("idle", {22'b0, mem_we, mem_addr}, 32'b0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rvalid0", {31'b0, rv0}, {31'b0, g0});
        chk("rvalid1", {31'b0, rv1}, {31'b0, g1});
        if (acc) begin
            lrd = p ? rd1 : rd0;
            chk("rdata", lrd, e);
            chk("err", {31'b0, p ? err1 : err0}, {31'b0, bad});
            req[p] = 1'b0;
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [1:0] sz, input logic [10:0] a, input logic [31:0] d);
        we[p] = w;
        size[p] = sz;
        addr[p] = a;
        wdata[p] = d;
        req[p] = 1'b1;
    endtask

    task automatic op(input int p, input logic w, input logic [1:0] sz, input logic [10:0] a, input logic [31:0] d);
        int n;
        set_port(p, w, sz, a, d);
        n = 0;
        while (req[p] && n < 4) begin
            cycle();
            n++;
        end
        if (req[p]) begin
            chk("op_timeout", 32'd0, 32'd1);
            req[p] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        last = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_clear();
        int n;
        logic anyg;
        n = 0;
        anyg = 1'b0;
        while (busy && n < 600) begin
            anyg |= gnt0 | gnt1;
            @(negedge clk);
            n++;
        end
        chk("clear_len", n, 32'd512);
        chk("clear_gnt", {31'b0, anyg}, 32'd0);
    endtask

    initial begin
        logic [5:0] seq;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; addr[p] = '0; we[p] = 1'b0; size[p] = '0; wdata[p] = '0;
        end
        last = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_rvalid", {30'b0, rv0, rv1}, 32'd0);
        chk("rst_err", {30'b0, err0, err1}, 32'd0);
        // p0 read of the last word is held through the clear.
        set_port(0, 1'b0, 2'd2, 11'h7FC, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear();
        cycle();
        chk("clear_read", lrd, 32'h0);

        op(1, 1'b1, 2'd2, 11'h010, 32'h1122_3344);
        op(1, 1'b1, 2'd0, 11'h012, 32'h0000_00AA);
        op(1, 1'b1, 2'd1, 11'h010, 32'h0000_BEEF);
        op(1, 1'b0, 2'd2, 11'h010, '0);
        chk("subword", lrd, 32'h11AA_BEEF);

        op(1, 1'b1, 2'd2, 11'h012, 32'hDEAD_BEEF);
        op(1, 1'b0, 2'd2, 11'h010, '0);
        chk("misaligned_nowrite", lrd, 32'h11AA_BEEF);

        op(0, 1'b1, 2'd3, 11'h020, 32'h1234_5678);
        op(0, 1'b0, 2'd2, 11'h020, '0);
        chk("illegal_nowrite", lrd, 32'h0);

        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++)
                if (!req[p] && $urandom_range(0, 2) != 0)
                    set_port(p, 1'($urandom_range(0, 1)),
                             $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2)),
                             11'($urandom_range(0, 127)), $urandom);
            cycle();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;

        // Reset lands in the response cycle of a p0 read.
        set_port(0, 1'b0, 2'd2, 11'h040, '0);
        #1;
        chk("mid_gnt", {31'b0, gnt0}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rvalid", {31'b0, rv0}, 32'd0);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        chk("mid_gnt_off", {31'b0, gnt0}, 32'd0);
        @(negedge clk);
        do_reset();
        chk("post_rst_rvalid", {30'b0, rv0, rv1}, 32'd0);
        wait_clear();

        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 2; p++)
                if (!req[p]) set_port(p, 1'b0, 2'd2, 11'($urandom_range(0, 511) * 4), '0);
            cycle();
            seq[i] = last;
        end
        chk("contention", {26'b0, seq}, 32'b101010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram32_arbiter.md
# bram32_arbiter

Two-port round-robin arbiter and sequencer that shares one `bram32` instance between an instruction-fetch requester (port 0) and a load/store requester (port 1). It translates byte address plus access size into the `bram32` word address and write sub-address, and checks alignment. It returns read data and write acknowledges one cycle after acceptance. It can optionally zero-fill the whole memory after reset before accepting traffic.

## Interface
Parameters:
- `DEPTH`, 512: words in the attached `bram32`; must match it.
- `CLEAR_ON_RESET`, 0: 1 = zero-fill all words after reset before granting.
- `ADDR_WIDTH`, localparam `$clog2(DEPTH)`: word address width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_pN_req`  in  1  request valid, N∈{0,1}; signals are held stable until granted.
- `i_pN_addr`  in  ADDR_WIDTH+2  byte address.
- `i_pN_we`  in  1  1 = write, 0 = read.
- `i_pN_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `i_pN_wdata`  in  32  write data, LSB-justified for sub-word writes.
- `o_pN_gnt`  out  1  request accepted this cycle (combinational).
- `o_pN_rvalid`  out  1  response valid, 1-cycle pulse.
- `o_pN_rdata`  out  32  full memory word.
- `o_pN_err`  out  1  qualifies `rvalid`; misaligned or illegal access.
- `o_mem_addr`  out  ADDR_WIDTH  to `bram32` `i_addr`.
- `o_mem_data`  out  32  to `i_data`.
- `o_mem_we`  out  1  to `i_we`.
- `o_mem_wr_subaddr`  out  3  to `i_wr_subaddr`.
- `i_mem_data`  in  32  from `o_data`.
- `o_busy`  out  1  high while clearing.

## Operation
- States are CLEAR and RUN. Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise RUN.
- CLEAR:
  - Each cycle drives `o_mem_we`=1, sub-address 1, data 0, and `o_mem_addr`=`r_clr_addr`, then increments the counter.
  - After writing address DEPTH-1, moves to RUN.
  - No grants are issued; `o_busy`=1.
- RUN, arbitration:
  - Exactly one request: grant it.
  - Both requesting: grant the port ≠ `r_last`.
  - `r_last` updates to the granted port on every accept.
- Accept means `req && gnt`. The granted port drives the memory signals:
  - `o_mem_addr = addr[ADDR_WIDTH+1:2]`.
  - `o_mem_data = wdata`.
- Sub-address:
  - word → 1.
  - half → 2+addr[1].
  - byte → 4+addr[1:0].
- Error cases: half with addr[0]=1, word with addr[1:0]≠0, or size 3.
  - The access is still granted, with `o_mem_we` forced 0.
  - The response carries `err`=1.
- Response:
  - `r_rsp_port` and `r_rsp_err` are registered on accept.
  - Next cycle: `o_pN_rvalid`=1 for that port, `o_pN_rdata=i_mem_data`, `o_pN_err=r_rsp_err`.
  - Writes also get `rvalid` as an acknowledge; `rdata` on writes holds the post-write word.
  - Responses have no backpressure.
- Idle (no accept, RUN): `o_mem_we`=0, `o_mem_addr`=0, sub-address 1, data 0.

## Timing
- Reset values:
  - All `gnt`, `rvalid`, `err` = 0; `rdata` follows `i_mem_data`.
  - `o_busy` = `CLEAR_ON_RESET`.
  - `r_last`=1, so port 0 wins the first tie.
  - `r_clr_addr`=0; response pipeline empty.
- `gnt` is combinational from `req` in RUN; zero-cycle accept.
- Read latency is exactly 1 cycle from the accept edge to `rvalid`. One accept per cycle; back-to-back accepts from alternating or the same port are allowed.
- Sustained contention gives strict alternation, so each port waits at most 1 cycle.
- CLEAR lasts exactly DEPTH cycles after reset deassertion; first possible grant is cycle DEPTH.
- Reset asserted mid-clear or mid-transaction drops any pending response (no `rvalid`) and restarts the sequence.
- Counter wrap: `r_clr_addr` is ADDR_WIDTH+1 bits, and the terminal compare is against DEPTH-1.
- The write data path is combinational through to `bram32`. The write takes effect at the accept edge.

## Structure
- Package `bram32_arb_pkg` holds:
  - size enum: `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
  - sub-address constants: `SUB_WORD`=1, `SUB_HALF0`=2, `SUB_BYTE0`=4.
  - state enum: `ST_CLEAR`, `ST_RUN`.
  - `function` for alignment check and sub-address encoding.
- One sub-module, `rr_arb2`: two-request round-robin grant with `r_last`, async active-low reset.
- `bram32` is instantiated by the parent, not inside this block.

## Test plan
- **Clear:** DEPTH=512, `CLEAR_ON_RESET`=1, memory preloaded with 0xFFFFFFFF.
  - `o_busy` is high for 512 cycles with no grants.
  - A p0 word read of addr 0x7FC then returns 0x00000000.
- **Sub-word writes:** p1 writes word 0x11223344 @0x10, byte 0xAA @0x12, half 0xBEEF @0x10.
  - A read @0x10 gives 0x11AABEEF, with `rvalid` exactly 1 cycle after each grant.
- **Contention:** p0 and p1 both hold `req` for 6 cycles after reset.
  - Grants alternate p0,p1,p0,p1,p0,p1.
  - Each `rvalid` goes to the matching port 1 cycle later.
- **Misaligned write:** p1 word write 0xDEADBEEF @0x12.
  - Granted with `o_mem_we`=0; next cycle `o_p1_rvalid`=1 and `o_p1_err`=1; memory unchanged.
- **Illegal size:** `size`=3 → `err`=1 response, no write.
- **Reset mid-operation:** assert `i_rst_n`=0 the cycle after a p0 read accept.
  - No `o_p0_rvalid` appears; outputs return to reset values immediately (async).
